// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and constants for the byte-wide memory port arbiter.
// Defining MEM_ARB_IO_STALL_EN lets io_full stall LS writes into IO space.
package mem_arbiter_pkg;
    localparam int ADDR_W = 32;
    localparam int MEM_IO_BIT = 17;
`ifdef MEM_ARB_IO_STALL_EN
    localparam bit IO_STALL_EN = 1'b1;
`else
    localparam bit IO_STALL_EN = 1'b0;
`endif
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [31:0] word_t;
    typedef logic [7:0] byte_t;
    localparam logic READ_SIGNAL = 1'b0;
    localparam logic WRITE_SIGNAL = 1'b1;
    localparam addr_t NULL_PTR = '0;
    localparam logic [2:0] SIZE_B = 3'd1;
    localparam logic [2:0] SIZE_H = 3'd2;
    localparam logic [2:0] SIZE_W = 3'd4;
    // Index of the final beat; any illegal size is treated as a word.
    function automatic logic [1:0] last_beat(input logic [2:0] size);
        return size == SIZE_B ? 2'd0 : size == SIZE_H ? 2'd1 : 2'd3;
    endfunction
endpackage

// File: rtl/mem_byte_seq.sv
// mem_byte_seq: beat counter, write byte shifter and read byte assembler for one transfer.
// Honours the IO write stall when MEM_ARB_IO_STALL_EN is defined.
module mem_byte_seq
    import mem_arbiter_pkg::*;
#(
    parameter int IO_BIT = MEM_IO_BIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        start,
    input  logic        abort,
    input  logic        op,
    input  addr_t       addr,
    input  word_t       wdata,
    input  logic [2:0]  size,
    input  logic        io_full,
    input  byte_t       mem_din,
    output addr_t       mem_a,
    output byte_t       mem_dout,
    output logic        mem_wr,
    output logic        fin,
    output word_t       rd_word
);
    logic on, busy, wr, cap_on;
    logic [1:0] cnt, last, cap_idx;
    addr_t base;
    word_t sh, acc;
    logic stall_new, stall_cur;

    assign stall_new = IO_STALL_EN & io_full & (op == WRITE_SIGNAL) & addr[IO_BIT];
    assign stall_cur = IO_STALL_EN & io_full & (wr == WRITE_SIGNAL) & base[IO_BIT];
    assign mem_a = on ? base + ADDR_W'(cnt) : NULL_PTR;
    assign mem_wr = on & (wr == WRITE_SIGNAL) & rdy;
    assign mem_dout = (on & (wr == WRITE_SIGNAL)) ? sh[7:0] : 8'h00;
    // RAM data lags the address by one cycle, so capture trails the beat that fetched it.
    assign rd_word = cap_on ? (acc | (word_t'(mem_din) << {cap_idx, 3'b000})) : acc;
    assign fin = (wr == WRITE_SIGNAL) ? (on & (cnt == last)) : (cap_on & (cap_idx == last));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            on <= 1'b0;
            busy <= 1'b0;
            wr <= READ_SIGNAL;
            cap_on <= 1'b0;
            cnt <= '0;
            last <= '0;
            cap_idx <= '0;
            base <= NULL_PTR;
            sh <= '0;
            acc <= '0;
        end else if (rdy) begin
            if (abort) begin
                on <= 1'b0;
                busy <= 1'b0;
                cap_on <= 1'b0;
            end else if (start) begin
                base <= addr;
                wr <= op;
                sh <= wdata;
                acc <= '0;
                cnt <= '0;
                last <= last_beat(size);
                busy <= 1'b1;
                on <= ~stall_new;
                cap_on <= 1'b0;
            end else begin
                cap_on <= on & (wr == READ_SIGNAL);
                cap_idx <= cnt;
                acc <= rd_word;
                if (on) begin
                    if (cnt == last) begin
                        on <= 1'b0;
                        busy <= 1'b0;
                    end else begin
                        cnt <= cnt + 2'd1;
                        sh <= sh >> 8;
                        on <= ~stall_cur;
                    end
                end else if (busy) begin
                    on <= ~stall_cur;
                end
            end
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the byte-wide memory port between IF fetches and LS accesses.
// Round-robin arbitration, IF flush and done pulses; beats come from mem_byte_seq.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int IO_BIT = MEM_IO_BIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              ls_req,
    input  logic              ls_wr,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [2:0]        ls_size,
    input  logic [31:0]       ls_wdata,
    output logic              ls_done,
    output logic [31:0]       ls_rdata,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_full
);
    typedef enum logic [2:0] {IDLE, GRANT_LS, GRANT_IF, RD, WR, DONE} state_t;

    state_t state;
    logic own_if, last_if, op;
    logic if_v, pick_if, start, flush_now, fin;
    word_t rd_word;

    assign if_v = if_req & ~if_flush;
    assign pick_if = if_v & (~ls_req | ~last_if);
    assign start = (state == IDLE) & (if_v | ls_req);
    assign flush_now = (state inside {GRANT_LS, GRANT_IF, RD, WR}) & own_if & if_flush;

    mem_byte_seq #(.IO_BIT(IO_BIT)) u_seq (
        .clk     (clk),
        .rst     (rst),
        .rdy     (rdy),
        .start   (start),
        .abort   (flush_now),
        .op      (pick_if ? READ_SIGNAL : ls_wr),
        .addr    (pick_if ? if_addr : ls_addr),
        .wdata   (ls_wdata),
        .size    (pick_if ? SIZE_W : ls_size),
        .io_full (io_full),
        .mem_din (mem_din),
        .mem_a   (mem_a),
        .mem_dout(mem_dout),
        .mem_wr  (mem_wr),
        .fin     (fin),
        .rd_word (rd_word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            own_if <= 1'b0;
            last_if <= 1'b1;
            op <= READ_SIGNAL;
            if_done <= 1'b0;
            ls_done <= 1'b0;
            if_data <= '0;
            ls_rdata <= '0;
        end else if (rdy) begin
            if_done <= 1'b0;
            ls_done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    state <= pick_if ? GRANT_IF : GRANT_LS;
                    own_if <= pick_if;
                    last_if <= pick_if;
                    op <= pick_if ? READ_SIGNAL : ls_wr;
                end
            end else if (state == DONE) begin
                state <= IDLE;
            end else if (flush_now) begin
                state <= DONE;
            end else if (fin) begin
                state <= DONE;
                if_done <= own_if;
                ls_done <= ~own_if;
                if (own_if)
                    if_data <= rd_word;
                else if (op == READ_SIGNAL)
                    ls_rdata <= rd_word;
            end else begin
                state <= (op == WRITE_SIGNAL) ? WR : RD;
            end
        end
    end
endmodule
